// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide responder for the muldiv request/answer interface.
// One operation in flight; every operation takes exactly 32 BUSY cycles. Flush and reset cancel it.
module muldiv_unit #(
    parameter int ID_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [31:0]         req_a,
    input  logic [31:0]         req_b,
    input  logic [ID_WIDTH-1:0] req_id,
    output logic                ans_valid,
    input  logic                ans_ready,
    output logic [31:0]         ans_hi,
    output logic [31:0]         ans_lo,
    output logic [ID_WIDTH-1:0] ans_id,
    input  logic                flush,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [4:0]          count;
    logic [63:0]         acc;
    logic [31:0]         opnd;
    logic                op_div;
    logic                neg_res;
    logic                neg_a;
    logic                div_zero;
    logic [ID_WIDTH-1:0] id_reg;

    logic                accept;
    logic                signed_op;
    logic                a_neg;
    logic                b_neg;
    logic [31:0]         a_abs;
    logic [31:0]         b_abs;
    logic [32:0]         mul_sum;
    logic [32:0]         div_shift;
    logic                div_ge;
    logic [31:0]         div_diff;
    logic [63:0]         iter_acc;
    logic [63:0]         prod_fix;
    logic [31:0]         quo_fix;
    logic [31:0]         rem_fix;
    logic [31:0]         fix_hi;
    logic [31:0]         fix_lo;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ans_valid = (state == DONE);
    assign accept    = req_valid && req_ready && !flush;

    assign signed_op = !req_op[0];
    assign a_neg     = signed_op && req_a[31];
    assign b_neg     = signed_op && req_b[31];
    assign a_abs     = a_neg ? -req_a : req_a;
    assign b_abs     = b_neg ? -req_b : req_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (count == 5'd0) state_next = DONE;
            DONE:    if (ans_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Multiply: acc = {partial high, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[31:0] - opnd;
        if (op_div) begin
            iter_acc = {(div_ge ? div_diff : div_shift[31:0]), acc[30:0], div_ge};
        end else begin
            iter_acc = {mul_sum, acc[31:1]};
        end
    end

    // With a zero divisor every step subtracts nothing, so the remainder ends up as |a| and
    // the usual dividend-sign fixup restores the original a.
    always_comb begin
        prod_fix = neg_res ? -iter_acc : iter_acc;
        quo_fix  = neg_res ? -iter_acc[31:0] : iter_acc[31:0];
        rem_fix  = neg_a ? -iter_acc[63:32] : iter_acc[63:32];
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (op_div) begin
            fix_hi = rem_fix;
            fix_lo = div_zero ? 32'hFFFF_FFFF : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_a    <= 1'b0;
            div_zero <= 1'b0;
            id_reg   <= '0;
            ans_hi   <= 32'd0;
            ans_lo   <= 32'd0;
            ans_id   <= '0;
        end else if (accept) begin
            count    <= 5'd31;
            op_div   <= req_op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_a    <= a_neg;
            div_zero <= (req_b == 32'd0);
            id_reg   <= req_id;
            if (req_op[1]) begin
                acc  <= {32'd0, a_abs};
                opnd <= b_abs;
            end else begin
                acc  <= {32'd0, b_abs};
                opnd <= a_abs;
            end
        end else if (state == BUSY && !flush) begin
            acc <= iter_acc;
            if (count != 5'd0) begin
                count <= count - 5'd1;
            end else begin
                ans_hi <= fix_hi;
                ans_lo <= fix_lo;
                ans_id <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int ID_WIDTH = 16;
    localparam int LIMIT    = 60;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [31:0]         req_a;
    logic [31:0]         req_b;
    logic [ID_WIDTH-1:0] req_id;
    logic                ans_valid;
    logic                ans_ready;
    logic [31:0]         ans_hi;
    logic [31:0]         ans_lo;
    logic [ID_WIDTH-1:0] ans_id;
    logic                flush;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.ID_WIDTH(ID_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_id(req_id),
        .ans_valid(ans_valid), .ans_ready(ans_ready),
        .ans_hi(ans_hi), .ans_lo(ans_lo), .ans_id(ans_id),
        .flush(flush), .busy(busy)
    );

    // Reference model: {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        longint p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'd3) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [ID_WIDTH-1:0] id);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_id    = id;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called in the first cycle after the accept cycle; returns the cycle index where ans_valid is seen.
    task automatic wait_answer(output int cycles);
        cycles = 1;
        while (ans_valid !== 1'b1 && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic take_answer();
        ans_ready = 1'b1;
        @(negedge clk);
        ans_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ans_valid !== 1'b0 || ans_hi !== 32'd0 || ans_lo !== 32'd0 || ans_id !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b hi=%h lo=%h id=%h, expected all zero",
                     ans_valid, ans_hi, ans_lo, ans_id);
        end
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got req_ready=%b busy=%b, expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_multu_latency();
        int cycles;
        ans_ready = 1'b1;
        issue(2'd1, 32'd7, 32'd6, 16'hA5A5);
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_after_accept: got busy=%b req_ready=%b, expected 1 0", busy, req_ready);
        end
        wait_answer(cycles);
        n_checks++;
        if (cycles !== 33) begin
            n_fail++;
            $display("[TB] FAIL multu_latency: got %0d, expected 33", cycles);
        end
        n_checks++;
        if (ans_hi !== 32'd0 || ans_lo !== 32'd42 || ans_id !== 16'hA5A5) begin
            n_fail++;
            $display("[TB] FAIL multu_7x6: got hi=%h lo=%h id=%h, expected 0 2a a5a5", ans_hi, ans_lo, ans_id);
        end
        @(negedge clk);
        ans_ready = 1'b0;
        n_checks++;
        if (ans_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multu_release: got valid=%b req_ready=%b, expected 0 1", ans_valid, req_ready);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        logic [63:0] exp;
        logic [ID_WIDTH-1:0] id;
        int cycles;
        vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'd5});
        vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{2'd3, 32'd100, 32'd7});
        vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2});
        vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{2'd2, 32'd1234, 32'd0});
        vecs.push_back('{2'd2, 32'hFFFF_FFFB, 32'd0});
        vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000});
        foreach (vecs[i]) begin
            id  = ID_WIDTH'(32'h0100 + i);
            exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, id);
            wait_answer(cycles);
            n_checks++;
            if (cycles !== 33) begin
                n_fail++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, expected 33", i, cycles);
            end
            n_checks++;
            if (ans_hi !== exp[63:32] || ans_lo !== exp[31:0] || ans_id !== id) begin
                n_fail++;
                $display("[TB] FAIL directed[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h id=%h, expected %h %h %h",
                         i, vecs[i].op, vecs[i].a, vecs[i].b, ans_hi, ans_lo, ans_id,
                         exp[63:32], exp[31:0], id);
            end
            take_answer();
            n_checks++;
            if (ans_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL directed_drop[%0d]: got valid=%b, expected 0", i, ans_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic [ID_WIDTH-1:0] id;
        int cycles;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            id  = ID_WIDTH'($urandom);
            exp = model(op, a, b);
            issue(op, a, b, id);
            wait_answer(cycles);
            n_checks++;
            if (cycles !== 33 || ans_hi !== exp[63:32] || ans_lo !== exp[31:0] || ans_id !== id) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got cyc=%0d hi=%h lo=%h id=%h, expected 33 %h %h %h",
                         i, op, a, b, cycles, ans_hi, ans_lo, ans_id, exp[63:32], exp[31:0], id);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take_answer();
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int early;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_a     = 32'd1234;
        req_b     = 32'd0;
        req_id    = 16'h1111;
        @(negedge clk);
        req_op = 2'd3;
        req_a  = 32'd100;
        req_b  = 32'd7;
        req_id = 16'h2222;
        early  = 0;
        cycles = 1;
        while (ans_valid !== 1'b1 && cycles < LIMIT) begin
            if (req_ready !== 1'b0) early++;
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (early != 0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_ready_low: got %0d cycles with req_ready high, expected 0", early);
        end
        n_checks++;
        if (cycles !== 33 || ans_hi !== 32'd1234 || ans_lo !== 32'hFFFF_FFFF || ans_id !== 16'h1111) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got cyc=%0d hi=%h lo=%h id=%h, expected 33 4d2 ffffffff 1111",
                     cycles, ans_hi, ans_lo, ans_id);
        end
        take_answer();
        n_checks++;
        if (req_ready !== 1'b1 || ans_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: got req_ready=%b valid=%b, expected 1 0", req_ready, ans_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second_accept: got busy=%b, expected 1", busy);
        end
        wait_answer(cycles);
        n_checks++;
        if (cycles !== 33 || ans_hi !== 32'd2 || ans_lo !== 32'd14 || ans_id !== 16'h2222) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got cyc=%0d hi=%h lo=%h id=%h, expected 33 2 e 2222",
                     cycles, ans_hi, ans_lo, ans_id);
        end
        take_answer();
    endtask

    task automatic test_hold();
        int cycles;
        logic [63:0] exp;
        exp = model(2'd0, 32'hFFFF_FFFD, 32'd5);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 16'h0BEE);
        wait_answer(cycles);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (ans_valid !== 1'b1 || ans_hi !== exp[63:32] || ans_lo !== exp[31:0] || ans_id !== 16'h0BEE) begin
                n_fail++;
                $display("[TB] FAIL hold[%0d]: got valid=%b hi=%h lo=%h id=%h, expected 1 %h %h 0bee",
                         i, ans_valid, ans_hi, ans_lo, ans_id, exp[63:32], exp[31:0]);
            end
            @(negedge clk);
        end
        take_answer();
        n_checks++;
        if (ans_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_release: got valid=%b req_ready=%b, expected 0 1", ans_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        int seen;
        int cycles;
        ans_ready = 1'b1;
        issue(2'd1, 32'd9, 32'd9, 16'h0F0F);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || ans_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_busy: got busy=%b req_ready=%b valid=%b, expected 0 1 0",
                     busy, req_ready, ans_valid);
        end
        seen = 0;
        repeat (40) begin
            if (ans_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_no_answer: got %0d valid cycles, expected 0", seen);
        end
        ans_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_a     = 32'd3;
        req_b     = 32'd3;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_blocks_accept: got busy=%b, expected 0", busy);
        end
        issue(2'd3, 32'd50, 32'd5, 16'h0C0C);
        wait_answer(cycles);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (ans_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_done: got valid=%b req_ready=%b, expected 0 1", ans_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_done();
        int cycles;
        issue(2'd1, 32'd123, 32'd456, 16'h7777);
        wait_answer(cycles);
        n_checks++;
        if (ans_valid !== 1'b1 || ans_lo !== 32'd56088) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_answer: got valid=%b lo=%h, expected 1 db18", ans_valid, ans_lo);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ans_valid !== 1'b0 || ans_hi !== 32'd0 || ans_lo !== 32'd0 || ans_id !== '0 ||
            req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_in_done: got valid=%b hi=%h lo=%h id=%h ready=%b busy=%b, expected 0 0 0 0 1 0",
                     ans_valid, ans_hi, ans_lo, ans_id, req_ready, busy);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_id    = '0;
        ans_ready = 1'b0;
        flush     = 1'b0;
        test_reset();
        test_multu_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
